qber_div_feeder: RTL and testbench
==================================

Name: qber_div_feeder

Overview:
- Upstream stage of the fixed-point sign-magnitude divider in the GHZ-QKD error-estimation path.
- Compares sifted bit pairs and accumulates error and total counts over a block.
- At block end, launches one division error/total, waits for completion, and publishes the QBER in Q-format with overflow and divide-by-zero flags.
- The divider is instantiated externally; this block drives its start/operand pins and consumes its result pins.

Parameters:
- N, 32, word width of divider operands and result (sign-magnitude: bit N-1 sign, N-2:0 magnitude).
- Q, 23, fractional bits of the divider result format.
- BLK_LEN, 4096, samples per estimation block; legal range 1 .. 2^(N-1)-1.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset
- i_valid  in  1  sample strobe; i_bit_a/i_bit_b are valid this cycle
- i_bit_a  in  1  sifted bit, party A
- i_bit_b  in  1  sifted bit, party B
- i_flush  in  1  end current block early (partial block)
- o_div_start  out  1  one-cycle start pulse to divider
- o_div_dividend  out  N  {1'b0, error count}
- o_div_divisor  out  N  {1'b0, total count}
- i_div_quotient  in  N  divider result
- i_div_complete  in  1  divider done level
- i_div_overflow  in  1  divider overflow flag
- o_qber  out  N  latched QBER, Q-format sign-magnitude
- o_qber_valid  out  1  one-cycle pulse when o_qber updates
- o_overflow  out  1  divider overflow for the last result
- o_zero_div  out  1  last block had zero samples; o_qber forced 0
- o_busy  out  1  high while not in ACCUM
- o_dropped  out  1  sticky: a sample arrived while busy

Behaviour:
- Reset: i_rst, synchronous, active-high; clock i_clk.
- Reset effect: state=ACCUM, counters=0, all outputs 0. Reset mid-division aborts; the divider's later completion is ignored.
- Counters: err_cnt and tot_cnt are N-1 bits wide.
  - ACCUM with i_valid: tot_cnt+1 and err_cnt+(i_bit_a^i_bit_b).
  - Both saturate at 2^(N-1)-1.
- Operands are raw integers fed as equally scaled Q values, so the quotient is err/tot in Q-format.
- ACCUM -> LAUNCH on the edge where the counted sample makes tot_cnt==BLK_LEN, or on i_flush.
  - i_valid together with i_flush: the sample is counted, then LAUNCH.
- i_flush with tot_cnt==0 (after the same-cycle sample): go to PUBLISH with zero_div=1, qber=0, overflow=0. No divider start.
- LAUNCH (1 cycle):
  - o_div_start=1.
  - Dividend/divisor are driven from the counters; they stay stable from LAUNCH through the end of WAIT.
  - Next state WAIT.
- WAIT:
  - The divider clears complete on the edge ending LAUNCH, so complete is sampled from the first WAIT cycle.
  - On i_div_complete=1: capture i_div_quotient and i_div_overflow, go to PUBLISH.
  - Expected wait is N+Q cycles (55 at default); no timeout.
- PUBLISH (1 cycle):
  - Register o_qber, o_overflow, o_zero_div; o_qber_valid=1.
  - Clear counters; return to ACCUM.
  - The first sample of the next block is accepted the cycle after PUBLISH.
- o_busy=1 in LAUNCH/WAIT/PUBLISH.
  - i_valid while busy: sample discarded, o_dropped set; cleared only by reset.
  - i_flush while busy: ignored.
- Output stability:
  - o_qber/o_overflow/o_zero_div hold until the next PUBLISH.
  - o_div_start is 0 in every state except LAUNCH.
- Latency from the block-ending sample to o_qber_valid: 1 (LAUNCH) + N+Q (WAIT) + 1 (PUBLISH) cycles.
- Bit pairs with x/z are not tolerated. The bench drives only 0/1.

Test Plan:
- Divider model: returns floor(dividend*2^Q/divisor) with complete low for N+Q cycles after start.
- Full-block, 4 errors: BLK_LEN=16, 16 samples with 4 mismatches.
  - Required: exactly one start pulse with dividend=4, divisor=16.
  - Required: o_qber=0x00200000, o_qber_valid pulse 57 cycles after the 16th sample, o_overflow=0, o_zero_div=0.
- All mismatches: BLK_LEN=16, 16 mismatches -> o_qber=0x00800000. No errors: -> o_qber=0.
- Flush a partial block: 3 samples (1 mismatch), then i_flush in the same cycle as a 4th, matching, sample.
  - Required: divisor=4, dividend=1, o_qber=0x00200000.
  - Separately, 3 samples with flush on an idle cycle -> o_qber=0x002AAAAA.
- Flush at zero: i_flush with no samples -> no o_div_start, o_qber_valid pulse next cycle, o_zero_div=1, o_qber=0.
- Busy and drop: i_valid asserted during WAIT -> o_dropped=1 sticky, counters unaffected, next block counts from 0. Model asserts i_div_overflow -> o_overflow=1 with result.
- Reset mid-operation: i_rst pulsed mid-WAIT -> all outputs 0, ACCUM, no o_qber_valid from the aborted division, next block results correct.

Source files
------------

// File: rtl/qber_div_feeder.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// qber_div_feeder: accumulates sifted-bit error/total counts per block and
// drives the external sign-magnitude divider to publish QBER.      Rev 1.0
// ----------------------------------------------------------------------------
module qber_div_feeder #(
    parameter int N       = 32,
    parameter int Q       = 23,
    parameter int BLK_LEN = 4096
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_valid,
    input  logic         i_bit_a,
    input  logic         i_bit_b,
    input  logic         i_flush,
    output logic         o_div_start,
    output logic [N-1:0] o_div_dividend,
    output logic [N-1:0] o_div_divisor,
    input  logic [N-1:0] i_div_quotient,
    input  logic         i_div_complete,
    input  logic         i_div_overflow,
    output logic [N-1:0] o_qber,
    output logic         o_qber_valid,
    output logic         o_overflow,
    output logic         o_zero_div,
    output logic         o_busy,
    output logic         o_dropped
);

    localparam logic [N-2:0] CNT_MAX = '1;
    localparam logic [N-2:0] BLK_END = (N-1)'(BLK_LEN);

    generate
        if (BLK_LEN < 1 || longint'(BLK_LEN) > ((longint'(1) << (N-1)) - 1) || Q > N-2) begin : g_param_check
            $error("qber_div_feeder: illegal BLK_LEN/Q for this N");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_ACCUM   = 2'd0,
        S_LAUNCH  = 2'd1,
        S_WAIT    = 2'd2,
        S_PUBLISH = 2'd3
    } state_t;

    state_t       state, state_next;
    logic [N-2:0] err_cnt, err_next;
    logic [N-2:0] tot_cnt, tot_next;
    logic         load_result;
    logic [N-1:0] qber_next;
    logic         ovf_next;
    logic         zd_next;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= S_ACCUM;
            err_cnt    <= '0;
            tot_cnt    <= '0;
            o_qber     <= '0;
            o_overflow <= 1'b0;
            o_zero_div <= 1'b0;
            o_dropped  <= 1'b0;
        end else begin
            state   <= state_next;
            err_cnt <= err_next;
            tot_cnt <= tot_next;
            if (load_result) begin
                o_qber     <= qber_next;
                o_overflow <= ovf_next;
                o_zero_div <= zd_next;
            end
            if (i_valid && state != S_ACCUM) begin
                o_dropped <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next  = state;
        err_next    = err_cnt;
        tot_next    = tot_cnt;
        load_result = 1'b0;
        qber_next   = i_div_quotient;
        ovf_next    = i_div_overflow;
        zd_next     = 1'b0;
        case (state)
            S_ACCUM: begin
                if (i_valid) begin
                    if (tot_cnt != CNT_MAX) begin
                        tot_next = tot_cnt + (N-1)'(1);
                    end
                    if (err_cnt != CNT_MAX) begin
                        err_next = err_cnt + (N-1)'(i_bit_a ^ i_bit_b);
                    end
                end
                if (i_valid && tot_next == BLK_END) begin
                    state_next = S_LAUNCH;
                end
                // A flush on an empty block bypasses the divider entirely.
                if (i_flush) begin
                    if (tot_next == '0) begin
                        state_next  = S_PUBLISH;
                        load_result = 1'b1;
                        qber_next   = '0;
                        ovf_next    = 1'b0;
                        zd_next     = 1'b1;
                    end else begin
                        state_next = S_LAUNCH;
                    end
                end
            end
            S_LAUNCH: begin
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (i_div_complete) begin
                    state_next  = S_PUBLISH;
                    load_result = 1'b1;
                end
            end
            S_PUBLISH: begin
                err_next   = '0;
                tot_next   = '0;
                state_next = S_ACCUM;
            end
            default: begin
                state_next = S_ACCUM;
            end
        endcase
    end

    // Counters are frozen outside ACCUM, so the operands hold through WAIT.
    assign o_div_dividend = {1'b0, err_cnt};
    assign o_div_divisor  = {1'b0, tot_cnt};
    assign o_div_start    = (state == S_LAUNCH);
    assign o_qber_valid   = (state == S_PUBLISH);
    assign o_busy         = (state != S_ACCUM);

endmodule
`default_nettype wire

// File: tb/tb_qber_div_feeder.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// tb_qber_div_feeder: scoreboard bench with a behavioural divider model. Rev 1.0
// ----------------------------------------------------------------------------
module tb_qber_div_feeder;

    localparam int N       = 32;
    localparam int Q       = 23;
    localparam int BLK_LEN = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         valid = 1'b0;
    logic         bit_a = 1'b0;
    logic         bit_b = 1'b0;
    logic         flush = 1'b0;
    logic         div_start;
    logic [N-1:0] div_dividend;
    logic [N-1:0] div_divisor;
    logic [N-1:0] div_quot = '0;
    logic         div_complete = 1'b1;
    logic         div_ovf = 1'b0;
    logic [N-1:0] qber;
    logic         qber_valid;
    logic         overflow;
    logic         zero_div;
    logic         busy;
    logic         dropped;
    logic         force_ovf = 1'b0;
    int           div_cnt = 0;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic [N-1:0] qber;
        logic         ovf;
        logic         zd;
    } res_t;
    typedef struct packed {
        logic [N-1:0] dd;
        logic [N-1:0] ds;
    } op_t;

    res_t res_q[$];
    op_t  op_q[$];
    res_t res_exp;
    op_t  op_exp;

    qber_div_feeder #(.N(N), .Q(Q), .BLK_LEN(BLK_LEN)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_valid        (valid),
        .i_bit_a        (bit_a),
        .i_bit_b        (bit_b),
        .i_flush        (flush),
        .o_div_start    (div_start),
        .o_div_dividend (div_dividend),
        .o_div_divisor  (div_divisor),
        .i_div_quotient (div_quot),
        .i_div_complete (div_complete),
        .i_div_overflow (div_ovf),
        .o_qber         (qber),
        .o_qber_valid   (qber_valid),
        .o_overflow     (overflow),
        .o_zero_div     (zero_div),
        .o_busy         (busy),
        .o_dropped      (dropped)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model_q(input logic [N-1:0] dd, input logic [N-1:0] ds);
        logic [63:0] num;
        logic [63:0] den;
        num = 64'(dd[N-2:0]) << Q;
        den = 64'(ds[N-2:0]);
        return (den == 64'd0) ? 64'd0 : num / den;
    endfunction

    function automatic logic [N-1:0] model_quot(input logic [N-1:0] dd, input logic [N-1:0] ds);
        logic [63:0] q64;
        q64 = model_q(dd, ds);
        return {1'b0, q64[N-2:0]};
    endfunction

    function automatic logic model_big(input logic [N-1:0] dd, input logic [N-1:0] ds);
        return model_q(dd, ds) >= (64'd1 << (N-1));
    endfunction

    // Divider model: complete drops on the start edge, returns after N+Q cycles.
    always @(posedge clk) begin
        if (div_start) begin
            div_quot     <= model_quot(div_dividend, div_divisor);
            div_ovf      <= force_ovf | model_big(div_dividend, div_divisor);
            div_complete <= 1'b0;
            div_cnt      <= N + Q - 1;
        end else if (div_cnt > 1) begin
            div_cnt <= div_cnt - 1;
        end else if (div_cnt == 1) begin
            div_cnt      <= 0;
            div_complete <= 1'b1;
        end
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (div_start) begin
            n_checks++;
            if (op_q.size() == 0) begin
                $display("FAIL unexpected_start: dividend=%h divisor=%h, required no start", div_dividend, div_divisor);
            end else begin
                n_pass++;
                op_exp = op_q.pop_front();
                n_checks++;
                if (div_dividend !== op_exp.dd)
                    $display("FAIL dividend: got %h expected %h", div_dividend, op_exp.dd);
                else
                    n_pass++;
                n_checks++;
                if (div_divisor !== op_exp.ds)
                    $display("FAIL divisor: got %h expected %h", div_divisor, op_exp.ds);
                else
                    n_pass++;
            end
        end
        if (qber_valid) begin
            n_checks++;
            if (res_q.size() == 0) begin
                $display("FAIL unexpected_qber_valid: qber=%h, required no result", qber);
            end else begin
                n_pass++;
                res_exp = res_q.pop_front();
                n_checks++;
                if (qber !== res_exp.qber)
                    $display("FAIL qber: got %h expected %h", qber, res_exp.qber);
                else
                    n_pass++;
                n_checks++;
                if (overflow !== res_exp.ovf)
                    $display("FAIL overflow: got %b expected %b", overflow, res_exp.ovf);
                else
                    n_pass++;
                n_checks++;
                if (zero_div !== res_exp.zd)
                    $display("FAIL zero_div: got %b expected %b", zero_div, res_exp.zd);
                else
                    n_pass++;
            end
        end
    end

    task automatic drive(input logic v, input logic a, input logic b, input logic f);
        @(negedge clk);
        valid = v;
        bit_a = a;
        bit_b = b;
        flush = f;
    endtask

    task automatic send_samples(input logic [15:0] mask, input int count, input logic flush_last);
        logic a;
        for (int i = 0; i < count; i++) begin
            a = 1'($urandom_range(0, 1));
            drive(1'b1, a, a ^ mask[i], flush_last && (i == count - 1));
        end
    endtask

    task automatic wait_valid(output int cycles);
        cycles = -1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            valid = 1'b0;
            flush = 1'b0;
            if (qber_valid) begin
                cycles = k;
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n_checks++; if (qber !== '0) $display("FAIL reset_qber: got %h expected 0", qber); else n_pass++;
        n_checks++; if (qber_valid !== 1'b0) $display("FAIL reset_qber_valid: got %b expected 0", qber_valid); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b expected 0", overflow); else n_pass++;
        n_checks++; if (zero_div !== 1'b0) $display("FAIL reset_zero_div: got %b expected 0", zero_div); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if (dropped !== 1'b0) $display("FAIL reset_dropped: got %b expected 0", dropped); else n_pass++;
        n_checks++; if (div_start !== 1'b0) $display("FAIL reset_start: got %b expected 0", div_start); else n_pass++;
        n_checks++; if (div_dividend !== '0) $display("FAIL reset_dividend: got %h expected 0", div_dividend); else n_pass++;
        n_checks++; if (div_divisor !== '0) $display("FAIL reset_divisor: got %h expected 0", div_divisor); else n_pass++;
    endtask

    task automatic test_full_block(input logic [15:0] mask, input logic [N-1:0] exp_err,
                                   input logic [N-1:0] exp_qber);
        int cycles;
        op_q.push_back('{dd: exp_err, ds: N'(BLK_LEN)});
        res_q.push_back('{qber: exp_qber, ovf: 1'b0, zd: 1'b0});
        send_samples(mask, BLK_LEN, 1'b0);
        wait_valid(cycles);
        n_checks++;
        if (cycles !== 57) $display("FAIL full_block_latency: got %0d expected 57", cycles); else n_pass++;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) $display("FAIL full_block_busy_after: got %b expected 0", busy); else n_pass++;
    endtask

    task automatic test_flush_partial();
        int cycles;
        op_q.push_back('{dd: N'(1), ds: N'(4)});
        res_q.push_back('{qber: 32'h0020_0000, ovf: 1'b0, zd: 1'b0});
        send_samples(16'b0010, 4, 1'b1);
        wait_valid(cycles);
        n_checks++;
        if (cycles !== 57) $display("FAIL flush_same_cycle_latency: got %0d expected 57", cycles); else n_pass++;
        drive(1'b0, 1'b0, 1'b0, 1'b0);

        op_q.push_back('{dd: N'(1), ds: N'(3)});
        res_q.push_back('{qber: 32'h002A_AAAA, ovf: 1'b0, zd: 1'b0});
        send_samples(16'b0001, 3, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        wait_valid(cycles);
        n_checks++;
        if (cycles !== 57) $display("FAIL flush_idle_latency: got %0d expected 57", cycles); else n_pass++;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_flush_zero();
        int cycles;
        res_q.push_back('{qber: '0, ovf: 1'b0, zd: 1'b1});
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        wait_valid(cycles);
        n_checks++;
        if (cycles !== 1) $display("FAIL flush_zero_latency: got %0d expected 1", cycles); else n_pass++;
        repeat (3) @(negedge clk);
        n_checks++;
        if (zero_div !== 1'b1 || qber !== '0)
            $display("FAIL flush_zero_hold: got zd=%b qber=%h expected zd=1 qber=0", zero_div, qber);
        else
            n_pass++;
    endtask

    task automatic test_busy_drop();
        int cycles;
        force_ovf = 1'b1;
        op_q.push_back('{dd: N'(2), ds: N'(BLK_LEN)});
        res_q.push_back('{qber: 32'h0010_0000, ovf: 1'b1, zd: 1'b0});
        send_samples(16'h0101, BLK_LEN, 1'b0);
        repeat (5) drive(1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (busy !== 1'b1) $display("FAIL busy_in_wait: got %b expected 1", busy); else n_pass++;
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b0, (i == 2));
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (dropped !== 1'b1) $display("FAIL dropped_set: got %b expected 1", dropped); else n_pass++;
        wait_valid(cycles);
        n_checks++;
        if (cycles < 0) $display("FAIL busy_drop_timeout: got no qber_valid within 200 cycles"); else n_pass++;
        force_ovf = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);

        op_q.push_back('{dd: N'(1), ds: N'(BLK_LEN)});
        res_q.push_back('{qber: 32'h0008_0000, ovf: 1'b0, zd: 1'b0});
        send_samples(16'h8000, BLK_LEN, 1'b0);
        wait_valid(cycles);
        n_checks++;
        if (cycles !== 57) $display("FAIL after_drop_latency: got %0d expected 57", cycles); else n_pass++;
        n_checks++;
        if (dropped !== 1'b1) $display("FAIL dropped_sticky: got %b expected 1", dropped); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int cycles;
        op_q.push_back('{dd: N'(8), ds: N'(BLK_LEN)});
        send_samples(16'h00FF, BLK_LEN, 1'b0);
        repeat (20) drive(1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (busy !== 1'b1) $display("FAIL reset_mid_busy_before: got %b expected 1", busy); else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (qber !== '0 || overflow !== 1'b0 || zero_div !== 1'b0 || busy !== 1'b0 || dropped !== 1'b0 || qber_valid !== 1'b0)
            $display("FAIL reset_mid_outputs: got qber=%h ovf=%b zd=%b busy=%b dropped=%b valid=%b expected all 0",
                     qber, overflow, zero_div, busy, dropped, qber_valid);
        else
            n_pass++;
        repeat (80) @(negedge clk);

        op_q.push_back('{dd: N'(3), ds: N'(BLK_LEN)});
        res_q.push_back('{qber: 32'h0018_0000, ovf: 1'b0, zd: 1'b0});
        send_samples(16'h0700, BLK_LEN, 1'b0);
        wait_valid(cycles);
        n_checks++;
        if (cycles !== 57) $display("FAIL reset_mid_next_latency: got %0d expected 57", cycles); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_full_block(16'h1248, N'(4),  32'h0020_0000);
        test_full_block(16'hFFFF, N'(16), 32'h0080_0000);
        test_full_block(16'h0000, N'(0),  32'h0000_0000);
        test_flush_partial();
        test_flush_zero();
        test_busy_drop();
        test_reset_mid();
        repeat (3) @(negedge clk);
        n_checks++;
        if (res_q.size() != 0 || op_q.size() != 0)
            $display("FAIL scoreboard_drain: got %0d results and %0d starts pending, expected 0", res_q.size(), op_q.size());
        else
            n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
